apb_regbank_slave: RTL and testbench

- APB4 completer (responder) with a parameterised, byte-strobed register bank, a programmable wait-state counter and PSLVERR generation.
- Answers transfers issued by the team's APB master and sits on one PSELx line (PSEL0 or PSEL1) of the shared APB bus.
- Register 0 is a read-only hardware status input. Register 1 is a privileged control register driven out to fabric. All other registers are general read/write.

---
 rtl/apb_regbank_pkg.sv | 26 ++
 rtl/apb_strb_regfile.sv | 37 +++
 rtl/apb_regbank_slave.sv | 123 ++++++++++++
 tb/tb_apb_regbank_slave.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/apb_regbank_pkg.sv
// Shared types, register indices and address-error decode for the APB register bank.
package apb_regbank_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  localparam int unsigned IDX_STATUS = 0;
  localparam int unsigned IDX_CTRL   = 1;
  localparam int unsigned CNT_W      = 4;

  // Flags misaligned, out-of-range, read-only and unprivileged-control accesses.
  function automatic logic addr_err(input logic [63:0] addr, input logic write,
                                    input logic [2:0] prot, input int unsigned num_regs);
    logic [63:0] word;
    logic        unused_prot_hi;
    word           = addr >> 2;
    unused_prot_hi = ^prot[2:1];
    addr_err = (addr[1:0] != 2'b00)
            || (addr >= (64'(num_regs) << 2))
            || (write && (word == 64'(IDX_STATUS)))
            || (write && (word == 64'(IDX_CTRL)) && !prot[0]);
  endfunction

endpackage

// File: rtl/apb_strb_regfile.sv
// Word register storage with byte-strobed writes and a combinational read port.
module apb_strb_regfile
  import apb_regbank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16,
  localparam int unsigned IDX_W     = $clog2(NUM_REGS),
  localparam int unsigned STRB_W    = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_W-1:0]     wstrb_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [DATA_WIDTH-1:0] ctrl_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];

  // Per-lane write: lanes with a cleared strobe hold their value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb_i[b]) mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];
  assign ctrl_o  = mem_q[IDX_CTRL];

endmodule

// File: rtl/apb_regbank_slave.sv
// APB4 completer: setup latch, wait-state counter, error decode and write-commit strobes.
module apb_regbank_slave
  import apb_regbank_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 2,
  localparam int unsigned IDX_W      = $clog2(NUM_REGS),
  localparam int unsigned STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [STRB_W-1:0]     PSTRB,
  input  logic [2:0]            PPROT,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic [DATA_WIDTH-1:0] status_in,
  output logic [DATA_WIDTH-1:0] ctrl_out,
  output logic                  wr_pulse,
  output logic [IDX_W-1:0]      wr_index
);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_W-1:0]     pstrb_q;
  logic [2:0]            pprot_q;
  logic                  wr_pulse_q;
  logic [IDX_W-1:0]      wr_index_q;

  logic [IDX_W-1:0]      idx_c;
  logic                  err_c;
  logic                  done_c;
  logic                  we_c;
  logic [DATA_WIDTH-1:0] rf_rdata;

  assign idx_c  = paddr_q[IDX_W+1:2];
  assign err_c  = addr_err(64'(paddr_q), pwrite_q, pprot_q, NUM_REGS);
  assign done_c = (state_q == ACCESS) && (cnt_q == '0) && PSEL && PENABLE;
  assign we_c   = done_c && pwrite_q && !err_c;

  // Transfer sequencing: latch the setup phase, count wait states, complete or abort.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      pstrb_q  <= '0;
      pprot_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            paddr_q  <= PADDR;
            pwrite_q <= PWRITE;
            pwdata_q <= PWDATA;
            pstrb_q  <= PSTRB;
            pprot_q  <= PPROT;
            cnt_q    <= CNT_W'(WAIT_STATES);
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (PENABLE) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Commit notification: one-cycle pulse plus index of the write just performed.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_pulse_q <= 1'b0;
      wr_index_q <= '0;
    end else begin
      wr_pulse_q <= we_c;
      if (we_c) wr_index_q <= idx_c;
    end
  end

  apb_strb_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_regfile (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .we_i    (we_c),
    .widx_i  (idx_c),
    .wdata_i (pwdata_q),
    .wstrb_i (pstrb_q),
    .ridx_i  (idx_c),
    .rdata_o (rf_rdata),
    .ctrl_o  (ctrl_out)
  );

  assign PREADY   = done_c;
  assign PSLVERR  = done_c && err_c;
  assign PRDATA   = (done_c && !err_c)
                  ? ((idx_c == IDX_W'(IDX_STATUS)) ? status_in : rf_rdata)
                  : '0;
  assign wr_pulse = wr_pulse_q;
  assign wr_index = wr_index_q;

endmodule

// File: tb/tb_apb_regbank_slave.sv
// Scoreboard bench for apb_regbank_slave: directed APB transfers, monitor compares completions.
module tb_apb_regbank_slave;

  localparam int unsigned WS = 2;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA, status_in, ctrl_out;
  logic [3:0]  PSTRB, wr_index;
  logic [2:0]  PPROT;
  logic        PREADY, PSLVERR, wr_pulse;

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  apb_regbank_slave #(
    .ADDR_WIDTH (32), .DATA_WIDTH (32), .NUM_REGS (16), .WAIT_STATES (WS)
  ) dut (
    .PCLK (PCLK), .PRESETn (PRESETn), .PSEL (PSEL), .PENABLE (PENABLE),
    .PWRITE (PWRITE), .PADDR (PADDR), .PWDATA (PWDATA), .PSTRB (PSTRB),
    .PPROT (PPROT), .PRDATA (PRDATA), .PREADY (PREADY), .PSLVERR (PSLVERR),
    .status_in (status_in), .ctrl_out (ctrl_out), .wr_pulse (wr_pulse),
    .wr_index (wr_index)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed transfer is matched against the oldest expectation.
  always @(negedge PCLK) begin
    if (PRESETn === 1'b1 && PREADY === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pready", 32'(PREADY), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pslverr", 32'(PSLVERR), 32'(e.err));
        if (e.rd || e.err) chk("prdata", PRDATA, e.err ? 32'h0 : e.data);
      end
    end
  end

  task automatic idle(input int n);
    PSEL = 1'b0; PENABLE = 1'b0;
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Full transfer starting at posedge+1; ends at posedge+1 after the completion edge.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input logic [2:0] prot,
                      input logic exp_err, input logic [31:0] exp_data);
    int waits;
    exp_t e;
    e.rd = !wr; e.err = exp_err; e.data = exp_data;
    exp_q.push_back(e);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr;
    PWDATA = data; PSTRB = strb; PPROT = prot;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    waits = 0;
    forever begin
      @(negedge PCLK);
      if (PREADY) break;
      waits++;
      if (waits > 40) break;
      @(posedge PCLK); #1;
    end
    chk("wait_states", 32'(waits), 32'(WS));
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    bit saw;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0; status_in = 32'h5A5A0001;

    // Reset values
    repeat (3) @(negedge PCLK);
    chk("rst_pready", 32'(PREADY), 32'h0);
    chk("rst_pslverr", 32'(PSLVERR), 32'h0);
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_ctrl_out", ctrl_out, 32'h0);
    chk("rst_wr_pulse", 32'(wr_pulse), 32'h0);
    chk("rst_wr_index", 32'(wr_index), 32'h0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    idle(1);

    // Privileged control write, then back-to-back readback
    xfer(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b001, 1'b0, 32'h0);
    chk("ctrl_after_wr", ctrl_out, 32'hDEADBEEF);
    chk("pulse_after_wr", 32'(wr_pulse), 32'h1);
    chk("index_after_wr", 32'(wr_index), 32'h1);
    xfer(1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 1'b0, 32'hDEADBEEF);
    chk("pulse_after_rd", 32'(wr_pulse), 32'h0);

    // Byte strobes and the zero-strobe no-op write
    xfer(1'b1, 32'h08, 32'hAABBCCDD, 4'hF, 3'b000, 1'b0, 32'h0);
    xfer(1'b1, 32'h08, 32'h11223344, 4'b0101, 3'b000, 1'b0, 32'h0);
    xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 1'b0, 32'hAA22CC44);
    idle(2);
    xfer(1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 3'b000, 1'b0, 32'h0);
    chk("pulse_nostrb", 32'(wr_pulse), 32'h1);
    chk("index_nostrb", 32'(wr_index), 32'h2);
    xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 1'b0, 32'hAA22CC44);

    // Error decode
    idle(2);
    xfer(1'b1, 32'h00, 32'h12345678, 4'hF, 3'b001, 1'b1, 32'h0);
    chk("pulse_ro_wr", 32'(wr_pulse), 32'h0);
    xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'b001, 1'b1, 32'h0);
    xfer(1'b0, 32'h06, 32'h0, 4'h0, 3'b001, 1'b1, 32'h0);
    xfer(1'b0, 32'h00, 32'h0, 4'h0, 3'b000, 1'b0, 32'h5A5A0001);

    // Privilege on the control register
    idle(2);
    xfer(1'b1, 32'h04, 32'h12345678, 4'hF, 3'b000, 1'b1, 32'h0);
    chk("pulse_unpriv", 32'(wr_pulse), 32'h0);
    chk("ctrl_unpriv", ctrl_out, 32'hDEADBEEF);
    xfer(1'b1, 32'h04, 32'h12345678, 4'hF, 3'b001, 1'b0, 32'h0);
    chk("ctrl_priv", ctrl_out, 32'h12345678);
    chk("index_priv", 32'(wr_index), 32'h1);

    // Abort: PSEL dropped in the first wait cycle
    idle(2);
    xfer(1'b1, 32'h0C, 32'h0BADF00D, 4'hF, 3'b000, 1'b0, 32'h0);
    idle(2);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0C;
    PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF; PPROT = 3'b000;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(negedge PCLK);
      if (PREADY || wr_pulse) saw = 1'b1;
    end
    chk("abort_quiet", 32'(saw), 32'h0);
    @(posedge PCLK); #1;
    xfer(1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0BADF00D);

    // Reset in the middle of a control write
    idle(1);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h04;
    PWDATA = 32'h87654321; PSTRB = 4'hF; PPROT = 3'b001;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    #1;
    chk("midrst_ctrl", ctrl_out, 32'h0);
    chk("midrst_pready", 32'(PREADY), 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    idle(1);
    xfer(1'b1, 32'h08, 32'hCAFEF00D, 4'hF, 3'b000, 1'b0, 32'h0);
    xfer(1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 1'b0, 32'hCAFEF00D);
    xfer(1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0);
    chk("ctrl_after_rst", ctrl_out, 32'h0);

    idle(3);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
